// File: rtl/booth_r4_seq_mult_if.sv
// rtl/booth_r4_seq_mult_if.sv - operand/product handshake bundle for booth_r4_seq_mult
// The sgn field exists only when BOOTH_MULT_UNSIGNED_EN is defined.
interface booth_r4_seq_mult_if #(
    parameter int WIDTH = 11
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     x;
`ifdef BOOTH_MULT_UNSIGNED_EN
    logic                 sgn;
`endif
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;
    logic                 busy;

`ifdef BOOTH_MULT_UNSIGNED_EN
    modport master (
        output in_valid, a, x, sgn, out_ready,
        input  in_ready, out_valid, product, busy
    );
    modport slave (
        input  in_valid, a, x, sgn, out_ready,
        output in_ready, out_valid, product, busy
    );
`else
    modport master (
        output in_valid, a, x, out_ready,
        input  in_ready, out_valid, product, busy
    );
    modport slave (
        input  in_valid, a, x, out_ready,
        output in_ready, out_valid, product, busy
    );
`endif
endinterface

// File: rtl/booth_r4_seq_mult.sv
// rtl/booth_r4_seq_mult.sv - sequential radix-4 Booth multiplier, one digit per clock
// BOOTH_MULT_UNSIGNED_EN adds a per-operation sgn select and one extension bit.
module booth_r4_seq_mult #(
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    booth_r4_seq_mult_if.slave bus
);
`ifdef BOOTH_MULT_UNSIGNED_EN
    localparam int XE = WIDTH + 1;
`else
    localparam int XE = WIDTH;
`endif
    localparam int NDIG = (XE + 1) / 2;
    localparam int XPW  = 2 * NDIG;
    localparam int PW   = 2 * WIDTH;
    localparam int CW   = $clog2(NDIG + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    state_t          state_nx;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   a_sh;
    logic [XPW-1:0]  x_sr;
    logic            x_prev;
    logic [CW-1:0]   cnt;
    logic            last_dig;

    logic [XE-1:0]   a_ext;
    logic [XE-1:0]   x_ext;
    logic [PW-1:0]   a_ld;
    logic [XPW-1:0]  x_ld;

`ifdef BOOTH_MULT_UNSIGNED_EN
    assign a_ext = {bus.sgn & bus.a[WIDTH-1], bus.a};
    assign x_ext = {bus.sgn & bus.x[WIDTH-1], bus.x};
`else
    assign a_ext = bus.a;
    assign x_ext = bus.x;
`endif
    // The extension bit already encodes signedness, so a signed widen is right for both modes.
    assign a_ld = PW'($signed(a_ext));
    assign x_ld = XPW'($signed(x_ext));

    assign last_dig = (cnt == CW'(NDIG - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nx = RUN;
            RUN:     if (last_dig)     state_nx = DONE;
            DONE:    if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
        bus.busy      = (state == RUN) || (state == DONE);
        bus.product   = acc;
    end

    logic [2:0]    win;
    logic          neg;
    logic [PW-1:0] pp_mag;
    logic [PW-1:0] addend;
    logic [PW-1:0] sum;

    // Negative digits reuse the accumulator adder: ones-complement plus a carry-in.
    always_comb begin
        win    = {x_sr[1:0], x_prev};
        neg    = 1'b0;
        pp_mag = '0;
        case (win)
            3'b001, 3'b010: pp_mag = a_sh;
            3'b011:         pp_mag = {a_sh[PW-2:0], 1'b0};
            3'b100: begin
                pp_mag = {a_sh[PW-2:0], 1'b0};
                neg    = 1'b1;
            end
            3'b101, 3'b110: begin
                pp_mag = a_sh;
                neg    = 1'b1;
            end
            default: pp_mag = '0;
        endcase
        addend = neg ? ~pp_mag : pp_mag;
        sum    = acc + addend + {{(PW-1){1'b0}}, neg};
    end

    // a_sh carries the 2*cnt weight, so no barrel shifter is needed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc    <= '0;
            a_sh   <= '0;
            x_sr   <= '0;
            x_prev <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        acc    <= '0;
                        cnt    <= '0;
                        a_sh   <= a_ld;
                        x_sr   <= x_ld;
                        x_prev <= 1'b0;
                    end
                end
                RUN: begin
                    acc    <= sum;
                    a_sh   <= a_sh << 2;
                    x_sr   <= x_sr >> 2;
                    x_prev <= x_sr[1];
                    if (!last_dig) cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// tb/tb_booth_r4_seq_mult.sv - self-checking bench for booth_r4_seq_mult
module tb_booth_r4_seq_mult;
    localparam int W = 11;
`ifdef BOOTH_MULT_UNSIGNED_EN
    localparam int XE = W + 1;
`else
    localparam int XE = W;
`endif
    localparam int NDIG = (XE + 1) / 2;

    logic clk;
    logic rst_n;
    booth_r4_seq_mult_if #(.WIDTH(W)) bus ();

    booth_r4_seq_mult #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    logic tb_sgn = 1'b1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [2*W-1:0] model_mult(input logic [W-1:0] av, input logic [W-1:0] xv,
                                                  input logic sv);
        longint sa;
        longint sx;
        if (sv) begin
            sa = longint'($signed(av));
            sx = longint'($signed(xv));
        end else begin
            sa = longint'({1'b0, av});
            sx = longint'({1'b0, xv});
        end
        return (2*W)'(sa * sx);
    endfunction

    // Reference: an accepted pair is pending until its product is taken; it is
    // visible from NDIG edges after acceptance.
    int            cyc = 0;
    bit            pending = 0;
    int            t0 = 0;
    int            last_t0 = 0;
    int            prev_t0 = 0;
    int            n_acc = 0;
    logic [2*W-1:0] exp_p = '0;
    bit            checking = 0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) begin
            pending = 0;
        end else if (!pending && bus.in_valid) begin
            pending = 1;
            t0      = cyc;
            exp_p   = model_mult(bus.a, bus.x, tb_sgn);
            prev_t0 = last_t0;
            last_t0 = cyc;
            n_acc++;
        end else if (pending && (cyc - 1) >= t0 + NDIG && bus.out_ready) begin
            pending = 0;
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            check("in_ready",  {63'd0, bus.in_ready},  {63'd0, !pending});
            check("out_valid", {63'd0, bus.out_valid}, {63'd0, pending && cyc >= t0 + NDIG});
            check("busy",      {63'd0, bus.busy},      {63'd0, pending});
            if (pending && cyc >= t0 + NDIG)
                check("product", 64'(bus.product), 64'(exp_p));
        end
    end

    task automatic send(input logic [W-1:0] av, input logic [W-1:0] xv, input logic sv);
        bit done;
        done = 0;
        bus.a = av;
        bus.x = xv;
        tb_sgn = sv;
`ifdef BOOTH_MULT_UNSIGNED_EN
        bus.sgn = sv;
`endif
        bus.in_valid = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            if (bus.in_ready) done = 1;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!done) check("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic recv(input int stall, output logic [2*W-1:0] p, output int lat);
        bit seen;
        seen = 0;
        lat  = 0;
        p    = '0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (bus.out_valid) seen = 1;
            else begin
                @(posedge clk);
                #1;
                lat++;
            end
        end
        if (!seen) begin
            check("out_valid_timeout", 64'd0, 64'd1);
        end else begin
            bus.out_ready = 1'b0;
            for (int i = 0; i < stall; i++) begin
                @(posedge clk);
                #1;
            end
            p = bus.product;
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic wait_acc(input int target);
        bit ok;
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (n_acc == target) ok = 1;
        end
        if (!ok) check("b2b_accept_timeout", 64'd0, 64'd1);
    endtask

    typedef struct {
        logic [W-1:0] av;
        logic [W-1:0] xv;
    } vec_t;
    vec_t vecs[8];

    logic [2*W-1:0] p;
    int             lat;

    initial begin
        rst_n = 1'b0;
        bus.in_valid  = 1'b1;
        bus.a         = 11'd7;
        bus.x         = -11'sd3;
        bus.out_ready = 1'b0;
`ifdef BOOTH_MULT_UNSIGNED_EN
        bus.sgn = 1'b1;
`endif
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("rst_product",   64'(bus.product), 64'd0);
        check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_busy",      {63'd0, bus.busy}, 64'd0);
        rst_n = 1'b1;
        check("rst_in_ready",  {63'd0, bus.in_ready}, 64'd1);
        checking = 1;

        send(11'd7, -11'sd3, 1'b1);
        recv(0, p, lat);
        check("p_7x-3",  64'(p), 64'h3FFFEB);
        check("latency", 64'(lat), 64'd6);

        send(-11'sd1024, -11'sd1024, 1'b1);
        recv(0, p, lat);
        check("p_min_sq", 64'(p), 64'h100000);

        vecs[0] = '{11'd123,      11'h2AA};
        vecs[1] = '{-11'sd77,     11'h155};
        vecs[2] = '{11'd1023,     11'h333};
        vecs[3] = '{-11'sd1,      -11'sd1};
        vecs[4] = '{11'd1023,     -11'sd1024};
        vecs[5] = '{11'd0,        11'd5};
        vecs[6] = '{-11'sd1024,   11'd1023};
        vecs[7] = '{11'h5A5,      11'h4CB};
        foreach (vecs[i]) begin
            send(vecs[i].av, vecs[i].xv, 1'b1);
            recv(i % 3, p, lat);
            check("p_vec", 64'(p), 64'(model_mult(vecs[i].av, vecs[i].xv, 1'b1)));
        end

        send(11'd123, 11'h2AA, 1'b1);
        recv(10, p, lat);
        check("p_stall", 64'(p), 64'd83886);

        bus.out_ready = 1'b1;
        bus.a = 11'd3;
        bus.x = -11'sd5;
        tb_sgn = 1'b1;
        bus.in_valid = 1'b1;
        wait_acc(n_acc + 1);
        bus.a = -11'sd7;
        bus.x = 11'd9;
        wait_acc(n_acc + 1);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 20 && pending; i++) begin
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b0;
        check("b2b_done", {63'd0, pending}, 64'd0);
        check("b2b_ii", 64'(last_t0 - prev_t0), 64'd8);

        send(11'd100, -11'sd50, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("abort_in_ready",  {63'd0, bus.in_ready},  64'd1);
        check("abort_out_valid", {63'd0, bus.out_valid}, 64'd0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
        end
        send(11'd5, 11'd5, 1'b1);
        recv(0, p, lat);
        check("p_5x5", 64'(p), 64'd25);

`ifdef BOOTH_MULT_UNSIGNED_EN
        send(11'd2047, 11'd2047, 1'b0);
        recv(0, p, lat);
        check("p_unsigned_max", 64'(p), 64'd4190209);
        send(11'd2047, 11'd2047, 1'b1);
        recv(0, p, lat);
        check("p_signed_m1", 64'(p), 64'd1);
        send(11'd1500, 11'h2AA, 1'b0);
        recv(1, p, lat);
        check("p_unsigned_mix", 64'(p), 64'd1023000);
`endif

        repeat (3) @(posedge clk);
        #1;
        checking = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end (got timeout, expected completion)");
        $fatal(1);
    end
endmodule
